// File: rtl/ps2_kbd_cmd_controller_pkg.sv
// Shared definitions for the PS/2 keyboard command sequencer:
// command/response bytes, FSM state encoding and abort codes.
package ps2_kbd_cmd_controller_pkg;

  // Host-to-keyboard commands
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;

  // Keyboard-to-host responses
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  // Wide enough for a 1 s timeout at 50 MHz
  localparam int TIMER_W = 26;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SEND_CMD     = 3'd1,
    ST_WAIT_ACK_CMD = 3'd2,
    ST_SEND_ARG     = 3'd3,
    ST_WAIT_ACK_ARG = 3'd4,
    ST_WAIT_BAT     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RETRIES  = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_BAT_FAIL = 2'd3
  } err_code_t;

  // SET-LED argument byte: {5'b0, caps, num, scroll}
  function automatic logic [7:0] led_arg(input logic [2:0] leds);
    return {5'b00000, leds};
  endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Response timeout counter: counts while enabled, clears on demand and
// flags expiry once the count has run for 'limit' enabled cycles.
module ps2_timeout_timer
  import ps2_kbd_cmd_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [TIMER_W-1:0] limit,
  output logic               expired
);

  logic [TIMER_W-1:0] cnt;

  // Count up while enabled; hold at the expiry point so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

  // Expiry is seen in the cycle whose closing edge is the limit-th edge
  // after the clear, so the aborting edge lands exactly 'limit' clocks later.
  assign expired = en && (cnt >= (limit - TIMER_W'(1)));

endmodule

// File: rtl/ps2_kbd_cmd_controller.sv
// Host-to-keyboard command sequencer for the PS/2 port. Runs the keyboard
// RESET (0xFF + BAT) and SET-LED (0xED + LED byte) exchanges, swallows the
// ACK/RESEND/BAT responses they produce and forwards everything else to the
// scan decoder.
//
//  state            | meaning
//  -----------------+----------------------------------------------------
//  ST_IDLE          | no sequence running; every rx byte is forwarded
//  ST_SEND_CMD      | presenting 0xFF or 0xED to the transmitter
//  ST_WAIT_ACK_CMD  | waiting for ACK/RESEND to the command byte
//  ST_SEND_ARG      | presenting the LED argument byte
//  ST_WAIT_ACK_ARG  | waiting for ACK/RESEND to the argument byte
//  ST_WAIT_BAT      | reset acknowledged, waiting for BAT pass/fail
module ps2_kbd_cmd_controller
  import ps2_kbd_cmd_controller_pkg::*;
#(
  parameter int ACK_TIMEOUT_CYC = 1_000_000,
  parameter int BAT_TIMEOUT_CYC = 50_000_000,
  parameter int MAX_RETRIES     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       tx_error,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] fwd_data,
  output logic       fwd_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       kbd_ok
);

  localparam logic [TIMER_W-1:0] ACK_LIMIT = TIMER_W'(ACK_TIMEOUT_CYC);
  localparam logic [TIMER_W-1:0] BAT_LIMIT = TIMER_W'(BAT_TIMEOUT_CYC);
  localparam int                 RETRY_W   = $clog2(MAX_RETRIES + 1) + 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t             state;
  logic               cmd_is_reset;
  logic [RETRY_W-1:0] retry;
  logic [2:0]         led_cur;
  logic               led_pend;
  logic [2:0]         led_pend_val;

  logic               in_wait;
  logic               bat_entry;
  logic               rx_consumed;
  logic               timer_clr;
  logic [TIMER_W-1:0] timer_limit;
  logic               timer_expired;

  // Response bytes belong to the sequencer only in the state expecting them.
  always_comb begin
    rx_consumed = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_WAIT_ACK_CMD, ST_WAIT_ACK_ARG:
          rx_consumed = (rx_data == RSP_ACK) || (rx_data == RSP_RESEND);
        ST_WAIT_BAT:
          rx_consumed = (rx_data == RSP_BAT_OK) || (rx_data == RSP_BAT_FAIL);
        default:
          rx_consumed = 1'b0;
      endcase
    end
  end

  assign in_wait = (state == ST_WAIT_ACK_CMD) || (state == ST_WAIT_ACK_ARG) ||
                   (state == ST_WAIT_BAT);

  // WAIT_ACK_CMD -> WAIT_BAT is a wait-to-wait move, so restart the timer there too.
  assign bat_entry   = (state == ST_WAIT_ACK_CMD) && rx_valid &&
                       (rx_data == RSP_ACK) && cmd_is_reset;
  assign timer_clr   = !in_wait || bat_entry;
  assign timer_limit = (state == ST_WAIT_BAT) ? BAT_LIMIT : ACK_LIMIT;

  ps2_timeout_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (in_wait),
    .limit   (timer_limit),
    .expired (timer_expired)
  );

  assign busy = (state != ST_IDLE);

  // Sequencer FSM with registered handshake, forwarding and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cmd_is_reset <= 1'b0;
      retry        <= '0;
      led_cur      <= '0;
      led_pend     <= 1'b0;
      led_pend_val <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      fwd_data     <= '0;
      fwd_valid    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      kbd_ok       <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      fwd_valid <= 1'b0;

      if (rx_valid && !rx_consumed) begin
        fwd_valid <= 1'b1;
        fwd_data  <= rx_data;
      end

      // An LED request while busy is parked; the most recent value wins.
      if (led_req && (state != ST_IDLE)) begin
        led_pend     <= 1'b1;
        led_pend_val <= led_val;
      end

      case (state)
        ST_IDLE: begin
          if (init_req) begin
            state        <= ST_SEND_CMD;
            tx_data      <= CMD_RESET;
            tx_valid     <= 1'b1;
            cmd_is_reset <= 1'b1;
            kbd_ok       <= 1'b0;
            retry        <= '0;
            if (led_req) begin
              led_pend     <= 1'b1;
              led_pend_val <= led_val;
            end
          end else if (led_req || led_pend) begin
            state        <= ST_SEND_CMD;
            tx_data      <= CMD_SET_LED;
            tx_valid     <= 1'b1;
            cmd_is_reset <= 1'b0;
            retry        <= '0;
            led_cur      <= led_req ? led_val : led_pend_val;
            led_pend     <= 1'b0;
          end
        end

        ST_SEND_CMD, ST_SEND_ARG: begin
          if (tx_error) begin
            if (retry == RETRY_MAX) begin
              state    <= ST_IDLE;
              tx_valid <= 1'b0;
              retry    <= '0;
              led_pend <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_RETRIES;
            end else begin
              retry <= retry + RETRY_W'(1);
            end
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= (state == ST_SEND_CMD) ? ST_WAIT_ACK_CMD : ST_WAIT_ACK_ARG;
          end
        end

        ST_WAIT_ACK_CMD, ST_WAIT_ACK_ARG: begin
          if (rx_valid && (rx_data == RSP_ACK)) begin
            retry <= '0;
            if (state == ST_WAIT_ACK_ARG) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else if (cmd_is_reset) begin
              state <= ST_WAIT_BAT;
            end else begin
              state    <= ST_SEND_ARG;
              tx_data  <= led_arg(led_cur);
              tx_valid <= 1'b1;
            end
          end else if ((rx_valid && (rx_data == RSP_RESEND)) || tx_error) begin
            if (retry == RETRY_MAX) begin
              state    <= ST_IDLE;
              retry    <= '0;
              led_pend <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_RETRIES;
            end else begin
              // tx_data still holds the byte being retried
              retry    <= retry + RETRY_W'(1);
              tx_valid <= 1'b1;
              state    <= (state == ST_WAIT_ACK_CMD) ? ST_SEND_CMD : ST_SEND_ARG;
            end
          end else if (timer_expired) begin
            state    <= ST_IDLE;
            retry    <= '0;
            led_pend <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end

        ST_WAIT_BAT: begin
          if (rx_valid && (rx_data == RSP_BAT_OK)) begin
            state  <= ST_IDLE;
            kbd_ok <= 1'b1;
            done   <= 1'b1;
          end else if (rx_valid && (rx_data == RSP_BAT_FAIL)) begin
            state    <= ST_IDLE;
            kbd_ok   <= 1'b0;
            led_pend <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_BAT_FAIL;
          end else if (timer_expired) begin
            state    <= ST_IDLE;
            led_pend <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end

        default: begin
          state    <= ST_IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_cmd_controller.sv
// Scoreboard bench for the PS/2 keyboard command sequencer. Expected tx
// bytes, forwarded bytes and completion events are queued as stimulus is
// driven and retired by a negedge monitor as the DUT produces them.
module tb_ps2_kbd_cmd_controller;

  localparam int ACK_TO = 100;
  localparam int BAT_TO = 500;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_req = 1'b0;
  logic       led_req = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       tx_error = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] fwd_data;
  logic       fwd_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       kbd_ok;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] tx_q[$];
  logic [7:0] fwd_q[$];
  int         evt_q[$];   // 0 = done, 1..3 = err with that code

  ps2_kbd_cmd_controller #(
    .ACK_TIMEOUT_CYC (ACK_TO),
    .BAT_TIMEOUT_CYC (BAT_TO),
    .MAX_RETRIES     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init_req  (init_req),
    .led_req   (led_req),
    .led_val   (led_val),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_error  (tx_error),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .fwd_data  (fwd_data),
    .fwd_valid (fwd_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .kbd_ok    (kbd_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Retire DUT outputs against the scoreboard queues.
  always @(negedge clk) begin : monitor
    int e;
    if (!reset) begin
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) chk("tx_unexpected", tx_q.size(), 1);
        else chk("tx_byte", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
      end
      if (fwd_valid) begin
        if (fwd_q.size() == 0) chk("fwd_unexpected", fwd_q.size(), 1);
        else chk("fwd_byte", {24'd0, fwd_data}, {24'd0, fwd_q.pop_front()});
      end
      if (done || err) begin
        if (evt_q.size() == 0) chk("evt_unexpected", evt_q.size(), 1);
        else begin
          e = evt_q.pop_front();
          chk("evt_kind", {30'd0, done, err}, (e == 0) ? 32'd2 : 32'd1);
          if (err) chk("err_code", {30'd0, err_code}, e);
        end
      end
    end
  end

  task automatic request(input logic do_init, input logic do_led, input logic [2:0] v,
                         input logic check_lat);
    @(posedge clk); #1;
    init_req = do_init;
    led_req  = do_led;
    led_val  = v;
    if (check_lat) begin
      @(negedge clk);
      chk("lat_cycle_n", tx_valid, 0);
    end
    @(posedge clk); #1;
    init_req = 1'b0;
    led_req  = 1'b0;
    if (check_lat) chk("lat_cycle_n1", tx_valid, 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic exp_fwd);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    if (exp_fwd) fwd_q.push_back(b);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("fwd_strobe", fwd_valid, exp_fwd);
  endtask

  // Returns in the cycle whose closing edge accepts a byte.
  task automatic wait_send(input string tag);
    int n = 0;
    while (!(tx_valid && tx_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, tx_valid && tx_ready, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  // Returns the edge count at which err was raised, or -1 if it never came.
  task automatic wait_err(input int budget, output int edge_no);
    int n = 0;
    edge_no = -1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (err) begin
        edge_no = cyc;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #400_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc_edge;
    int err_edge;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_kbd_ok", kbd_ok, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    reset = 1'b0;

    // 1: keyboard reset, ACK then BAT pass, nothing forwarded
    tx_q.push_back(8'hFF);
    evt_q.push_back(0);
    request(1'b1, 1'b0, 3'b000, 1'b1);
    wait_send("t1_send");
    send_rx(8'hFA, 1'b0);
    chk("t1_busy_bat", busy, 1);
    send_rx(8'hAA, 1'b0);
    chk("t1_done", done, 1);
    wait_idle("t1_idle", 10);
    chk("t1_kbd_ok", kbd_ok, 1);

    // 2: SET-LED 3'b101
    tx_q.push_back(8'hED);
    tx_q.push_back(8'h05);
    evt_q.push_back(0);
    request(1'b0, 1'b1, 3'b101, 1'b0);
    wait_send("t2_send_cmd");
    chk("t2_busy_send", busy, 1);
    send_rx(8'hFA, 1'b0);
    chk("t2_busy_arg", busy, 1);
    wait_send("t2_send_arg");
    send_rx(8'hFA, 1'b0);
    chk("t2_done", done, 1);
    chk("t2_kbd_ok_kept", kbd_ok, 1);

    // 3: four RESENDs exhaust the retries; a parked LED request is dropped
    repeat (4) tx_q.push_back(8'hED);
    evt_q.push_back(1);
    request(1'b0, 1'b1, 3'b010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_send("t3_send");
      if (i == 1) request(1'b0, 1'b1, 3'b111, 1'b0);
      send_rx(8'hFE, 1'b0);
    end
    chk("t3_err", err, 1);
    chk("t3_err_code", err_code, 1);
    repeat (20) @(negedge clk);
    chk("t3_no_pending", busy, 0);

    // 4a: no ACK -> timeout exactly ACK_TO edges after acceptance
    tx_q.push_back(8'hFF);
    evt_q.push_back(2);
    request(1'b1, 1'b0, 3'b000, 1'b0);
    chk("t4_kbd_ok_clr", kbd_ok, 0);
    wait_send("t4_send");
    acc_edge = cyc + 1;
    wait_err(ACK_TO + 50, err_edge);
    chk("t4_ack_timeout_edges", err_edge - acc_edge, ACK_TO);
    wait_idle("t4_idle", 5);

    // 4b: ACK then BAT fail
    tx_q.push_back(8'hFF);
    evt_q.push_back(3);
    request(1'b1, 1'b0, 3'b000, 1'b0);
    wait_send("t4b_send");
    send_rx(8'hFA, 1'b0);
    send_rx(8'hFC, 1'b0);
    chk("t4b_err_code", err_code, 3);
    chk("t4b_kbd_ok", kbd_ok, 0);

    // 4c: ACK then no BAT -> timeout BAT_TO edges after the ACK
    tx_q.push_back(8'hFF);
    evt_q.push_back(2);
    request(1'b1, 1'b0, 3'b000, 1'b0);
    wait_send("t4c_send");
    send_rx(8'hFA, 1'b0);
    acc_edge = cyc;
    wait_err(BAT_TO + 50, err_edge);
    chk("t4c_bat_timeout_edges", err_edge - acc_edge, BAT_TO);

    // 5: forwarding in IDLE and around a SET-LED exchange
    send_rx(8'h1C, 1'b1);
    send_rx(8'hFA, 1'b1);
    send_rx(8'hAA, 1'b1);
    tx_q.push_back(8'hED);
    tx_q.push_back(8'h03);
    evt_q.push_back(0);
    request(1'b0, 1'b1, 3'b011, 1'b0);
    wait_send("t5_send_cmd");
    send_rx(8'h1C, 1'b1);
    send_rx(8'hAA, 1'b1);
    send_rx(8'hFA, 1'b0);
    wait_send("t5_send_arg");
    send_rx(8'hF0, 1'b1);
    send_rx(8'hFA, 1'b0);
    chk("t5_done", done, 1);

    // 6: init and LED together; later LED value while busy wins
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'hED);
    tx_q.push_back(8'h06);
    evt_q.push_back(0);
    evt_q.push_back(0);
    request(1'b1, 1'b1, 3'b010, 1'b0);
    request(1'b0, 1'b1, 3'b110, 1'b0);
    send_rx(8'hFA, 1'b0);
    send_rx(8'hAA, 1'b0);
    chk("t6_init_done", done, 1);
    wait_send("t6_led_cmd");
    send_rx(8'hFA, 1'b0);
    wait_send("t6_led_arg");
    send_rx(8'hFA, 1'b0);
    chk("t6_led_done", done, 1);
    chk("t6_kbd_ok", kbd_ok, 1);

    // 6b: reset in WAIT_ACK with an LED request parked
    tx_q.push_back(8'hED);
    request(1'b0, 1'b1, 3'b001, 1'b0);
    wait_send("t6b_send");
    request(1'b0, 1'b1, 3'b100, 1'b0);
    chk("t6b_busy_before", busy, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6b_rst_busy", busy, 0);
    chk("t6b_rst_tx_valid", tx_valid, 0);
    chk("t6b_rst_done_err", {done, err}, 0);
    chk("t6b_rst_kbd_ok", kbd_ok, 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6b_pending_cleared", busy, 0);

    chk("tx_q_drained", tx_q.size(), 0);
    chk("fwd_q_drained", fwd_q.size(), 0);
    chk("evt_q_drained", evt_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
